// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller:
// FSM state encoding, the hard-wired zero register, and the source-match helper.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   // A write to x0 never creates a dependency, so it is excluded here.
   function automatic logic src_match(
      input logic [4:0] rd,
      input logic [4:0] rs1,
      input logic [4:0] rs2
   );
      return (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   // Count up on inc, sticking at the maximum value.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + ONE;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control strobes: freeze on outstanding data-memory access,
// squash on taken branch, one-cycle stall on load-use, plus perf counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_memread,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_hazard,
   output logic             if_id_hazard,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
   localparam logic [WC_W-1:0] WC_ONE = WC_W'(1);

   state_t          state;
   state_t          state_nxt;
   logic [WC_W-1:0] wait_cnt;
   logic [WC_W-1:0] wait_nxt;
   logic            timeout_nxt;
   logic            flush_q;

   logic            freeze;
   logic            flush;
   logic            load_use;

   // Hazard/flush/freeze decode; everything is forced low while in reset.
   always_comb begin
      freeze       = (mem_req & ~mem_ready) | (state == ERR);
      flush        = ex_branch_taken & ~freeze & ~flush_q;
      load_use     = ex_memread & src_match(ex_rd, id_rs1, id_rs2)
                     & ~flush & ~freeze;
      pc_hazard    = 1'b0;
      if_id_hazard = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if (arst_n) begin
         unique case (1'b1)
            freeze: begin
               pc_hazard    = 1'b1;
               if_id_hazard = 1'b1;
            end
            flush: begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               id_ex_en     = 1'b1;
               ex_mem_en    = 1'b1;
               mem_wb_en    = 1'b1;
            end
            load_use: begin
               pc_hazard    = 1'b1;
               if_id_hazard = 1'b1;
               id_ex_bubble = 1'b1;
               id_ex_en     = 1'b1;
               ex_mem_en    = 1'b1;
               mem_wb_en    = 1'b1;
            end
            default: begin
               id_ex_en     = 1'b1;
               ex_mem_en    = 1'b1;
               mem_wb_en    = 1'b1;
            end
         endcase
      end
   end

   // Memory-wait FSM next state, wait counter and timeout flag.
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      timeout_nxt = mem_timeout;
      unique case (state)
         RUN: begin
            if (mem_req && !mem_ready) begin
               state_nxt = MEM_WAIT;
               wait_nxt  = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = RUN;
               wait_nxt  = '0;
            end else if (wait_cnt == WC_MAX) begin
               state_nxt   = ERR;
               timeout_nxt = 1'b1;
            end else begin
               wait_nxt = wait_cnt + WC_ONE;
            end
         end
         ERR: begin
            state_nxt = ERR;
         end
         default: begin
            state_nxt = RUN;
            wait_nxt  = '0;
         end
      endcase
   end

   // State, wait counter, sticky timeout and the one-shot flush guard.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state       <= RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_nxt;
         mem_timeout <= timeout_nxt;
         flush_q     <= if_id_flush;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc    (pc_hazard),
      .cnt    (stall_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_flush_cnt (
      .clk    (clk),
      .arst_n (arst_n),
      .inc    (if_id_flush),
      .cnt    (flush_cnt)
   );

endmodule
